timed_cmd_queue: RTL
====================

Name: timed_cmd_queue

Overview:
Downstream consumer of the 64-bit VITA time counter. It queues time-tagged 32-bit commands written over the settings bus and emits each one as a single-cycle strobe when vita_time reaches the command's timestamp. Commands whose time has already passed are flagged late. It drives timed register writes, such as gain, tune or GPIO changes, aligned to the shared timebase.

Parameters:
DEPTH_LOG2, 3, log2 of queue depth (entries = 2**DEPTH_LOG2)
BASE, 0, settings-bus base address

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
set_stb  in  1  settings bus write strobe
set_addr  in  8  settings bus address
set_data  in  32  settings bus data
vita_time  in  64  current time {seconds,ticks} from the time counter
cmd_stb  out  1  one-cycle pulse: command issued
cmd_data  out  32  payload of issued command, valid with cmd_stb, held until next issue
cmd_late  out  1  issued command was late, valid with cmd_stb, held until next issue
fill  out  DEPTH_LOG2+1  entries currently queued, including the entry loaded in compare stage
overflow  out  1  sticky: a push was dropped

Behaviour:
- Register map:
  - BASE+0 TIME_HI: stage time[63:32].
  - BASE+1 TIME_LO: stage time[31:0].
  - BASE+2 CMD: push {TIME_HI,TIME_LO,set_data}.
  - BASE+3 CTRL: bit0 flush, bit1 clear overflow.
- Staged TIME_HI/TIME_LO persist across pushes. Reset value is 0.
- Storage: circular FIFO of 96-bit entries with DEPTH_LOG2-bit read/write pointers and a DEPTH_LOG2+1-bit count. Pointers wrap modulo depth.
- Push:
  - A CMD write when count < 2**DEPTH_LOG2 writes the entry and increments count the next cycle.
  - A CMD write when full is dropped and sets overflow the next cycle.
  - Full is evaluated on the pre-pop count. A push in the same cycle as a pop while full is still dropped.
- fill equals count and is registered.
- FSM states: EMPTY, LOAD, WAIT, FIRE.
  - EMPTY: count == 0. Go to LOAD when count != 0.
  - LOAD: one cycle. Copy the FIFO head into head_time[63:0] and head_data[31:0]. Go to WAIT.
  - WAIT: match = (vita_time >= head_time), unsigned 64-bit. On match, capture late = (vita_time != head_time) and go to FIRE. Otherwise stay in WAIT.
  - FIRE: one cycle.
    - Assert cmd_stb, drive cmd_data = head_data and cmd_late = captured late.
    - Pop: advance rptr and decrement count.
    - Next state is LOAD if count-1 != 0, else EMPTY.
- Latency:
  - cmd_stb is high in the cycle after the cycle in which vita_time == head_time.
  - A push into an empty queue needs at least 3 cycles to issue: count update, LOAD, WAIT.
  - Minimum spacing between issues is 3 cycles (LOAD, WAIT, FIRE). Identical timestamps issue in order; the second issue is late.
- Time jumps: if vita_time skips over head_time (set_imm, PPS load, MIMO sync), the first WAIT cycle with vita_time > head_time fires with cmd_late = 1. A backward jump simply keeps waiting.
- Ordering: strict FIFO. No sorting. A later-queued command never issues before an earlier one, even if its time is earlier.
- Flush (CTRL bit0):
  - Next cycle: count = 0, both pointers = 0, FSM = EMPTY.
  - A pending head is discarded without cmd_stb.
  - Flush wins over a simultaneous push, whose entry is dropped without setting overflow.
  - Flush also wins over FIRE: cmd_stb still pulses that cycle, but the queue ends empty.
- Clear overflow (CTRL bit1): overflow <= 0. If a dropped push occurs in the same cycle, set wins.
- Reset:
  - FSM = EMPTY, count = 0, pointers = 0, head regs = 0, staged time = 0.
  - cmd_stb = 0, cmd_data = 0, cmd_late = 0, fill = 0, overflow = 0.
  - Reset mid-WAIT discards all entries, with no strobe.
- All outputs are registered. No combinational path from vita_time to any output.

Test Plan:
- Reset, then vita_time counting from 0x0000_0005_0000_0000. Push time 0x0000_0005_0000_0064, data 0xA5A5_0001 -> single cmd_stb in the cycle after vita_time = ..._0064, cmd_data = 0xA5A50001, cmd_late = 0, fill 1 -> 0.
- vita_time = 0x10_0000_0000. Push time 0x0F_0000_0000 -> cmd_stb within 4 cycles of the CMD write, cmd_late = 1.
- Push 3 commands at times T, T, T+1, with T 50 ticks ahead -> three strobes in push order, 3 cycles apart. Lateness is 0, 1, 1.
- DEPTH_LOG2 = 3, push 9 commands far in the future -> fill = 8, overflow = 1. Clear overflow -> overflow = 0. Flush -> fill = 0 and no strobes ever issued.
- Command pending at T + 1000. Jump vita_time from T + 10 to T + 2000 -> strobe with cmd_late = 1. Then push at T + 2010 -> on-time strobe, cmd_late = 0.
- Assert rst while in WAIT with 2 entries queued -> fill = 0, overflow = 0, no cmd_stb afterward. A post-reset push issues normally.

Source files
------------

// File: rtl/timed_cmd_queue.sv
// -----------------------------------------------------------------------------
// timed_cmd_queue
//
// Queues time-tagged 32-bit commands written over the settings bus and issues
// each one as a single-cycle strobe once vita_time reaches its timestamp.
// Commands issued after their timestamp are flagged late. Issue order is
// strict FIFO: a queued command never overtakes an earlier one.
//
// Register map (relative to BASE):
//   +0 TIME_HI  stage time[63:32]
//   +1 TIME_LO  stage time[31:0]
//   +2 CMD      push {TIME_HI, TIME_LO, set_data}
//   +3 CTRL     bit0 flush queue, bit1 clear overflow
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   set_stb        settings bus write strobe
//   set_addr[7:0]  settings bus address
//   set_data[31:0] settings bus data
//   vita_time[63:0] current time {seconds, ticks}
//   cmd_stb        one-cycle pulse: command issued
//   cmd_data[31:0] payload of the issued command, held until next issue
//   cmd_late       issued command was late, held until next issue
//   fill           entries queued, including the one in the compare stage
//   overflow       sticky: a push was dropped because the queue was full
// -----------------------------------------------------------------------------
module timed_cmd_queue #(
    parameter int         DEPTH_LOG2 = 3,
    parameter logic [7:0] BASE       = 8'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_stb,
    input  logic [7:0]            set_addr,
    input  logic [31:0]           set_data,
    input  logic [63:0]           vita_time,
    output logic                  cmd_stb,
    output logic [31:0]           cmd_data,
    output logic                  cmd_late,
    output logic [DEPTH_LOG2:0]   fill,
    output logic                  overflow
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {EMPTY, LOAD, WAIT, FIRE} state_t;

    state_t                state;
    logic [31:0]           time_hi;
    logic [31:0]           time_lo;
    logic [95:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   count;
    logic [63:0]           head_time;
    logic [31:0]           head_data;

    logic wr_time_hi, wr_time_lo, wr_cmd, wr_ctrl;
    logic flush, clr_ovf, full, push, drop, pop;

    assign wr_time_hi = set_stb && (set_addr == BASE);
    assign wr_time_lo = set_stb && (set_addr == BASE + 8'd1);
    assign wr_cmd     = set_stb && (set_addr == BASE + 8'd2);
    assign wr_ctrl    = set_stb && (set_addr == BASE + 8'd3);

    assign flush   = wr_ctrl && set_data[0];
    assign clr_ovf = wr_ctrl && set_data[1];

    // count never exceeds DEPTH, so its MSB alone means "full". Full is judged
    // on the pre-pop count, so a push alongside a pop while full is dropped.
    assign full = count[DEPTH_LOG2];
    // Flush discards a simultaneous push silently, without flagging overflow.
    assign push = wr_cmd && !full && !flush;
    assign drop = wr_cmd && full && !flush;
    assign pop  = (state == FIRE);

    assign fill = count;

    // NOTE: the storage array has no reset; entries are only ever read after
    // a push has written them, so clearing it would add logic for nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {time_hi, time_lo, set_data};
        end
    end

    // Staged time, pointers, occupancy and the sticky overflow flag.
    // NOTE: every clocked block uses non-blocking assignments so that all
    // registers update together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            time_hi  <= '0;
            time_lo  <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_time_hi) time_hi <= set_data;
            if (wr_time_lo) time_lo <= set_data;

            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            // A dropped push in the same cycle as a clear leaves the flag set.
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    // Issue sequencer. The strobe is raised on the WAIT->FIRE transition so
    // it is high during FIRE, one cycle after the matching vita_time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            head_time <= '0;
            head_data <= '0;
            cmd_stb   <= 1'b0;
            cmd_data  <= '0;
            cmd_late  <= 1'b0;
        end else begin
            cmd_stb <= 1'b0;
            if (flush) begin
                // Any loaded head is abandoned without a strobe. A strobe
                // already in flight (state FIRE) still completes this cycle.
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (count != '0) state <= LOAD;
                    end
                    LOAD: begin
                        head_time <= mem[rptr][95:32];
                        head_data <= mem[rptr][31:0];
                        state     <= WAIT;
                    end
                    WAIT: begin
                        // Unsigned compare: a forward jump past head_time
                        // fires late, a backward jump simply keeps waiting.
                        if (vita_time >= head_time) begin
                            cmd_stb  <= 1'b1;
                            cmd_data <= head_data;
                            cmd_late <= (vita_time != head_time);
                            state    <= FIRE;
                        end
                    end
                    FIRE: begin
                        // The pop happens this cycle; count still holds the
                        // pre-pop value, so one entry left means empty after.
                        if (count != {{DEPTH_LOG2{1'b0}}, 1'b1}) state <= LOAD;
                        else                                      state <= EMPTY;
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule
